// File: rtl/endian_swap_unit.sv
// -----------------------------------------------------------------------------
// endian_swap_unit
//
// Byte-order converter between a big-endian bus and little-endian storage.
// With swap_en=1, output byte k is input byte N_BYTES-1-k, and byte enable k
// is input enable N_BYTES-1-k. With swap_en=0 the word and enables pass through
// unchanged. The swap is its own inverse, so the same unit can serve both the
// write path and the read path.
//
// Parameters
//   N_BYTES : word width in bytes (>= 1, odd values allowed)
//   REG_OUT : 0 = combinational outputs, 1 = outputs registered on CLK
//   N_BITS  : derived word width (N_BYTES*8)
//
// Ports
//   CLK         in   clock, only used when REG_OUT=1
//   nRST        in   asynchronous active-low reset, only used when REG_OUT=1
//   swap_en     in   1 = reverse byte order, 0 = pass through
//   valid_in    in   input qualifier
//   word_in     in   input word, byte k = word_in[8k+7:8k]
//   byte_en_in  in   per-byte enables aligned with word_in
//   word_out    out  converted word
//   byte_en_out out  converted byte enables
//   valid_out   out  output qualifier
// -----------------------------------------------------------------------------
module endian_swap_unit #(
  parameter int N_BYTES = 4,
  parameter bit REG_OUT = 1'b0,
  localparam int N_BITS = N_BYTES * 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              swap_en,
  input  logic              valid_in,
  input  logic [N_BITS-1:0] word_in,
  input  logic [N_BYTES-1:0] byte_en_in,
  output logic [N_BITS-1:0] word_out,
  output logic [N_BYTES-1:0] byte_en_out,
  output logic              valid_out
);

  logic [N_BITS-1:0]  word_swp;
  logic [N_BYTES-1:0] be_swp;
  logic [N_BITS-1:0]  word_d;
  logic [N_BYTES-1:0] be_d;
  logic               valid_d;

  // Pure routing: each output byte is wired to exactly one input byte, so an
  // X/Z on one input byte only reaches its mirrored output byte. For odd
  // N_BYTES the middle byte maps onto itself; N_BYTES=1 degenerates to a wire.
  always_comb begin
    word_swp = '0;
    be_swp   = '0;
    for (int k = 0; k < N_BYTES; k++) begin
      word_swp[8*k +: 8] = word_in[8*(N_BYTES-1-k) +: 8];
      be_swp[k]          = byte_en_in[N_BYTES-1-k];
    end
  end

  always_comb begin
    word_d  = word_in;
    be_d    = byte_en_in;
    valid_d = valid_in;
    if (swap_en) begin
      word_d = word_swp;
      be_d   = be_swp;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [N_BITS-1:0]  word_q;
      logic [N_BYTES-1:0] be_q;
      logic               valid_q;

      // Data and enables load every cycle regardless of valid_in; swap_en is
      // sampled together with its own word, so mode changes apply per word.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          word_q  <= '0;
          be_q    <= '0;
          valid_q <= 1'b0;
        end else begin
          word_q  <= word_d;
          be_q    <= be_d;
          valid_q <= valid_d;
        end
      end

      assign word_out    = word_q;
      assign byte_en_out = be_q;
      assign valid_out   = valid_q;
    end else begin : g_comb
      // Clock and reset are intentionally ignored in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = CLK ^ nRST;

      assign word_out    = word_d;
      assign byte_en_out = be_d;
      assign valid_out   = valid_d;
    end
  endgenerate

endmodule

// File: tb/tb_endian_swap_unit.sv
module tb_endian_swap_unit;

  logic CLK;
  logic nRST;
  int   checks;
  int   failures;

  // N_BYTES=4, combinational
  logic        a_swap, a_vin, a_vout;
  logic [31:0] a_win, a_wout;
  logic [3:0]  a_bein, a_beout;

  // N_BYTES=3, combinational
  logic        b_swap, b_vin, b_vout;
  logic [23:0] b_win, b_wout;
  logic [2:0]  b_bein, b_beout;

  // N_BYTES=1, combinational
  logic        c_swap, c_vin, c_vout;
  logic [7:0]  c_win, c_wout;
  logic [0:0]  c_bein, c_beout;

  // cascaded pair, N_BYTES=4, combinational
  logic        d_vin, d_vm, d_vout;
  logic [31:0] d_win, d_wm, d_wout;
  logic [3:0]  d_bein, d_bem, d_beout;

  // N_BYTES=4, registered
  logic        r_swap, r_vin, r_vout;
  logic [31:0] r_win, r_wout;
  logic [3:0]  r_bein, r_beout;

  endian_swap_unit #(.N_BYTES(4), .REG_OUT(1'b0)) u_a (
    .CLK(CLK), .nRST(nRST), .swap_en(a_swap), .valid_in(a_vin),
    .word_in(a_win), .byte_en_in(a_bein),
    .word_out(a_wout), .byte_en_out(a_beout), .valid_out(a_vout));

  endian_swap_unit #(.N_BYTES(3), .REG_OUT(1'b0)) u_b (
    .CLK(CLK), .nRST(nRST), .swap_en(b_swap), .valid_in(b_vin),
    .word_in(b_win), .byte_en_in(b_bein),
    .word_out(b_wout), .byte_en_out(b_beout), .valid_out(b_vout));

  endian_swap_unit #(.N_BYTES(1), .REG_OUT(1'b0)) u_c (
    .CLK(CLK), .nRST(nRST), .swap_en(c_swap), .valid_in(c_vin),
    .word_in(c_win), .byte_en_in(c_bein),
    .word_out(c_wout), .byte_en_out(c_beout), .valid_out(c_vout));

  endian_swap_unit #(.N_BYTES(4), .REG_OUT(1'b0)) u_d1 (
    .CLK(CLK), .nRST(nRST), .swap_en(1'b1), .valid_in(d_vin),
    .word_in(d_win), .byte_en_in(d_bein),
    .word_out(d_wm), .byte_en_out(d_bem), .valid_out(d_vm));

  endian_swap_unit #(.N_BYTES(4), .REG_OUT(1'b0)) u_d2 (
    .CLK(CLK), .nRST(nRST), .swap_en(1'b1), .valid_in(d_vm),
    .word_in(d_wm), .byte_en_in(d_bem),
    .word_out(d_wout), .byte_en_out(d_beout), .valid_out(d_vout));

  endian_swap_unit #(.N_BYTES(4), .REG_OUT(1'b1)) u_r (
    .CLK(CLK), .nRST(nRST), .swap_en(r_swap), .valid_in(r_vin),
    .word_in(r_win), .byte_en_in(r_bein),
    .word_out(r_wout), .byte_en_out(r_beout), .valid_out(r_vout));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic test_reset();
    nRST = 1'b0;
    a_swap = 1'b1; a_vin = 1'b1; a_win = 32'h1122_3344; a_bein = 4'b0001;
    r_swap = 1'b1; r_vin = 1'b1; r_win = 32'hFFFF_FFFF; r_bein = 4'b1111;
    @(posedge CLK); #1;
    checks++;
    if (r_wout !== 32'h0 || r_beout !== 4'h0 || r_vout !== 1'b0) begin
      failures++;
      $display("FAIL reset_reg_outputs: got w=%h be=%b v=%b want w=0 be=0 v=0",
               r_wout, r_beout, r_vout);
    end
    // Combinational build ignores reset.
    checks++;
    if (a_wout !== 32'h4433_2211 || a_beout !== 4'b1000 || a_vout !== 1'b1) begin
      failures++;
      $display("FAIL reset_comb_unaffected: got w=%h be=%b v=%b want w=44332211 be=1000 v=1",
               a_wout, a_beout, a_vout);
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_swap4();
    logic [31:0] win  [4] = '{32'h1122_3344, 32'hDEAD_BEEF, 32'hA1B2_C3D4, 32'h0000_00FF};
    logic [3:0]  bein [4] = '{4'b0001,       4'b0011,       4'b1010,       4'b1110};
    logic        sw   [4] = '{1'b1,          1'b0,          1'b1,          1'b1};
    logic        vin  [4] = '{1'b1,          1'b0,          1'b1,          1'b0};
    logic [31:0] wexp [4] = '{32'h4433_2211, 32'hDEAD_BEEF, 32'hD4C3_B2A1, 32'hFF00_0000};
    logic [3:0]  bexp [4] = '{4'b1000,       4'b0011,       4'b0101,       4'b0111};
    for (int i = 0; i < 4; i++) begin
      a_win = win[i]; a_bein = bein[i]; a_swap = sw[i]; a_vin = vin[i];
      #1;
      checks++;
      if (a_wout !== wexp[i] || a_beout !== bexp[i] || a_vout !== vin[i]) begin
        failures++;
        $display("FAIL swap4[%0d]: got w=%h be=%b v=%b want w=%h be=%b v=%b",
                 i, a_wout, a_beout, a_vout, wexp[i], bexp[i], vin[i]);
      end
    end
  endtask

  task automatic test_swap3();
    logic [23:0] win  [3] = '{24'hAA_BB_CC, 24'hAA_BB_CC, 24'h01_02_03};
    logic [2:0]  bein [3] = '{3'b011,      3'b011,      3'b100};
    logic        sw   [3] = '{1'b1,        1'b0,        1'b1};
    logic [23:0] wexp [3] = '{24'hCC_BB_AA, 24'hAA_BB_CC, 24'h03_02_01};
    logic [2:0]  bexp [3] = '{3'b110,      3'b011,      3'b001};
    for (int i = 0; i < 3; i++) begin
      b_win = win[i]; b_bein = bein[i]; b_swap = sw[i]; b_vin = sw[i];
      #1;
      checks++;
      if (b_wout !== wexp[i] || b_beout !== bexp[i] || b_vout !== sw[i]) begin
        failures++;
        $display("FAIL swap3[%0d]: got w=%h be=%b v=%b want w=%h be=%b v=%b",
                 i, b_wout, b_beout, b_vout, wexp[i], bexp[i], sw[i]);
      end
    end
  endtask

  task automatic test_swap1();
    c_win = 8'h5A; c_bein = 1'b1; c_swap = 1'b1; c_vin = 1'b1;
    #1;
    checks++;
    if (c_wout !== 8'h5A || c_beout !== 1'b1 || c_vout !== 1'b1) begin
      failures++;
      $display("FAIL swap1_identity: got w=%h be=%b v=%b want w=5a be=1 v=1",
               c_wout, c_beout, c_vout);
    end
  endtask

  task automatic test_involution();
    for (int i = 0; i < 1000; i++) begin
      d_win  = $urandom;
      d_bein = 4'($urandom_range(0, 15));
      d_vin  = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (d_wout !== d_win || d_beout !== d_bein || d_vout !== d_vin) begin
        failures++;
        $display("FAIL involution[%0d]: got w=%h be=%b v=%b want w=%h be=%b v=%b",
                 i, d_wout, d_beout, d_vout, d_win, d_bein, d_vin);
      end
    end
  endtask

  task automatic test_reg_latency();
    @(negedge CLK);
    r_win = 32'h0; r_bein = 4'b0000; r_swap = 1'b1; r_vin = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    r_win = 32'h0102_0304; r_bein = 4'b0011; r_vin = 1'b1;
    #1;
    checks++;
    if (r_wout !== 32'h0 || r_beout !== 4'b0000 || r_vout !== 1'b0) begin
      failures++;
      $display("FAIL reg_not_before_edge: got w=%h be=%b v=%b want w=0 be=0000 v=0",
               r_wout, r_beout, r_vout);
    end
    @(posedge CLK); #1;
    checks++;
    if (r_wout !== 32'h0403_0201 || r_beout !== 4'b1100 || r_vout !== 1'b1) begin
      failures++;
      $display("FAIL reg_after_edge: got w=%h be=%b v=%b want w=04030201 be=1100 v=1",
               r_wout, r_beout, r_vout);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] win  [5] = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hCAFE_F00D, 32'h0A0B_0C0D};
    logic [3:0]  bein [5] = '{4'b0001,       4'b1100,       4'b0110,       4'b1011,       4'b0111};
    logic        sw   [5] = '{1'b1,          1'b0,          1'b1,          1'b0,          1'b1};
    logic        vin  [5] = '{1'b1,          1'b0,          1'b1,          1'b1,          1'b0};
    logic [31:0] wexp [5] = '{32'h4433_2211, 32'h5566_7788, 32'hCCBB_AA99, 32'hCAFE_F00D, 32'h0D0C_0B0A};
    logic [3:0]  bexp [5] = '{4'b1000,       4'b1100,       4'b0110,       4'b1011,       4'b1110};
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      r_win = win[i]; r_bein = bein[i]; r_swap = sw[i]; r_vin = vin[i];
      @(posedge CLK); #1;
      checks++;
      if (r_wout !== wexp[i] || r_beout !== bexp[i] || r_vout !== vin[i]) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got w=%h be=%b v=%b want w=%h be=%b v=%b",
                 i, r_wout, r_beout, r_vout, wexp[i], bexp[i], vin[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    // Load a nonzero word so the reset effect is visible.
    @(negedge CLK);
    r_win = 32'hA5A5_0F0F; r_bein = 4'b1111; r_swap = 1'b0; r_vin = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (r_wout !== 32'hA5A5_0F0F || r_beout !== 4'b1111 || r_vout !== 1'b1) begin
      failures++;
      $display("FAIL preload: got w=%h be=%b v=%b want w=a5a50f0f be=1111 v=1",
               r_wout, r_beout, r_vout);
    end
    #1;
    nRST = 1'b0;
    #1;
    checks++;
    if (r_wout !== 32'h0 || r_beout !== 4'b0000 || r_vout !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_immediate: got w=%h be=%b v=%b want w=0 be=0000 v=0",
               r_wout, r_beout, r_vout);
    end
    @(negedge CLK);
    r_win = 32'h1234_5678; r_bein = 4'b0001; r_swap = 1'b1; r_vin = 1'b1;
    #1;
    nRST = 1'b1;
    #1;
    checks++;
    if (r_wout !== 32'h0 || r_beout !== 4'b0000 || r_vout !== 1'b0) begin
      failures++;
      $display("FAIL release_no_edge: got w=%h be=%b v=%b want w=0 be=0000 v=0",
               r_wout, r_beout, r_vout);
    end
    @(posedge CLK); #1;
    checks++;
    if (r_wout !== 32'h7856_3412 || r_beout !== 4'b1000 || r_vout !== 1'b1) begin
      failures++;
      $display("FAIL first_edge_after_release: got w=%h be=%b v=%b want w=78563412 be=1000 v=1",
               r_wout, r_beout, r_vout);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    nRST = 1'b0;
    a_swap = 1'b0; a_vin = 1'b0; a_win = '0; a_bein = '0;
    b_swap = 1'b0; b_vin = 1'b0; b_win = '0; b_bein = '0;
    c_swap = 1'b0; c_vin = 1'b0; c_win = '0; c_bein = '0;
    d_vin = 1'b0; d_win = '0; d_bein = '0;
    r_swap = 1'b0; r_vin = 1'b0; r_win = '0; r_bein = '0;

    test_reset();
    test_swap4();
    test_swap3();
    test_swap1();
    test_involution();
    test_reg_latency();
    test_back_to_back();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
